axilite_read_channel: RTL and testbench
=======================================

Name: axilite_read_channel

Overview:
Complete AXI4-Lite read slave: AR address handshake, address decode against a parametrised window of NUM_WORDS registers, programmable read latency, and R channel with full backpressure. Register contents arrive on a flattened bus from the register bank. A per-read strobe drives side-effect (clear-on-read) registers, and a saturating counter tracks error responses. It sits between the interconnect's AR/R channels and the coprocessor register file, alongside the write-channel block.

Parameters:
DATA_WIDTH, 32, R data width in bits; must be 32 or 64.
ADDR_SIZE, 32, AR address width in bits.
NUM_WORDS, 4, number of readable words; must be >= 1.
BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.
READ_LATENCY, 1, cycles from AR accept to data sample; range 1..8.
ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
data  in  NUM_WORDS*DATA_WIDTH  register contents; word i is data[i*DATA_WIDTH +: DATA_WIDTH].
araddr  in  ADDR_SIZE  AR byte address.
arvalid  in  1  AR valid.
arready  out  1  AR ready (registered).
rdata  out  DATA_WIDTH  read data (registered).
rresp  out  2  response: 0 OKAY, 2 SLVERR, 3 DECERR (registered).
rvalid  out  1  R valid (registered).
rready  in  1  R ready.
rd_strobe  out  1  one-cycle pulse for each successful read.
rd_index  out  $clog2(NUM_WORDS) (min 1)  word index qualified by rd_strobe.
err_count  out  ERR_CNT_WIDTH  saturating count of non-OKAY responses.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, arready=1, rvalid=0, rdata=0, rresp=0, rd_strobe=0, rd_index=0, err_count=0, latency counter=0.
- States: IDLE -> WAIT -> RESP -> IDLE. One transaction outstanding at a time.
- IDLE: arready=1. At edge E0 with arvalid && arready: capture araddr, deassert arready, decode, load counter = READ_LATENCY-1, go to WAIT.
- Decode on the captured address. offset = araddr - BASE_ADDR, computed ADDR_SIZE wide.
  - araddr < BASE_ADDR, or offset >> log2(DATA_WIDTH/8) >= NUM_WORDS -> DECERR.
  - Otherwise, nonzero low log2(DATA_WIDTH/8) offset bits -> SLVERR.
  - Otherwise -> OKAY, index = offset >> log2(DATA_WIDTH/8).
  - DECERR takes precedence over SLVERR.
- WAIT: counter decrements each edge. While counter==0, rd_strobe=1 and rd_index=index, but only if OKAY. At the next edge (E0+READ_LATENCY):
  - rdata = data word[index] as sampled at that edge, or 0 on error.
  - rresp = decoded response; rvalid=1; go to RESP.
- rvalid rises exactly READ_LATENCY+1 edges... precisely: rvalid is high from edge E0+READ_LATENCY.
- RESP: rvalid, rdata and rresp stay stable until an edge with rready=1. At that edge: rvalid=0, arready=1, go to IDLE.
- err_count: increments by 1 at the edge where a non-OKAY response is loaded; holds at all-ones (saturates).
- Throughput: with rready held high, a new AR can be accepted every READ_LATENCY+2 cycles.
- arvalid during WAIT/RESP is ignored (arready=0). The master must hold the address per AXI.
- rready high in IDLE/WAIT has no effect.
- rst asserted mid-transaction: the transaction is abandoned, all outputs return to reset values immediately, and no strobe or response is issued afterward.
- Changes on data after the sample edge do not affect rdata.

Test Plan:
- Reset: assert rst mid-cycle -> arready=1, rvalid=0, rresp=0, err_count=0 immediately; hold arvalid=0 10 cycles -> no rvalid.
- Aligned read, defaults: word2=32'hDEADBEEF, araddr=8 accepted at E0 -> rd_strobe=1, rd_index=2 in cycle E0..E1; rvalid=1, rdata=32'hDEADBEEF, rresp=0 from E1; rready=1 at E2 -> rvalid=0, arready=1.
- Backpressure and latency: READ_LATENCY=3, araddr=4, rready=0 for 6 cycles, word1 changed after sample edge -> rvalid rises at E3; rdata holds the sampled value throughout; arready=0 until the rready edge.
- Errors: araddr=6 -> rresp=2, rdata=0, no rd_strobe; araddr=16 (NUM_WORDS=4) -> rresp=3; BASE_ADDR=32 with araddr=4 -> rresp=3; err_count=3 afterward.
- Saturation: ERR_CNT_WIDTH=2, five erroneous reads -> err_count sticks at 3.
- Reset during WAIT (READ_LATENCY=4, rst after E1) -> no rvalid or rd_strobe ever; next read after release completes normally with rresp=0.

Source files
------------

// File: rtl/axilite_read_channel.sv
// ---------------------------------------------------------------------------
// axilite_read_channel
//
// AXI4-Lite read slave for the coprocessor register file. It accepts one AR
// beat at a time, decodes it against a window of NUM_WORDS registers starting
// at BASE_ADDR, waits READ_LATENCY cycles, then presents the word on the R
// channel and holds it until the master takes it. Successful reads pulse
// rd_strobe/rd_index so clear-on-read registers can react. Non-OKAY
// responses bump a saturating error counter.
//
// Handshake: a transfer occurs on a rising clk edge where valid && ready.
// Once rvalid is raised, rdata/rresp stay frozen until that transfer edge.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   data         flattened register contents, word i = data[i*DATA_WIDTH +: DATA_WIDTH]
//   araddr       AR byte address
//   arvalid      AR valid            arready  AR ready (registered)
//   rdata        R data (registered) rresp    0 OKAY, 2 SLVERR, 3 DECERR
//   rvalid       R valid (registered) rready  R ready
//   rd_strobe    one-cycle pulse per successful read
//   rd_index     word index, meaningful while rd_strobe is high
//   err_count    saturating count of non-OKAY responses
// ---------------------------------------------------------------------------
module axilite_read_channel #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_SIZE     = 32,
    parameter int NUM_WORDS     = 4,
    parameter int BASE_ADDR     = 0,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16,
    localparam int IDX_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] data,
    input  logic [ADDR_SIZE-1:0]            araddr,
    input  logic                            arvalid,
    output logic                            arready,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                      rresp,
    output logic                            rvalid,
    input  logic                            rready,
    output logic                            rd_strobe,
    output logic [IDX_W-1:0]                rd_index,
    output logic [ERR_CNT_WIDTH-1:0]        err_count
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    localparam logic [ADDR_SIZE-1:0] BASE_A  = ADDR_SIZE'(BASE_ADDR);
    localparam logic [ADDR_SIZE-1:0] WORDS_A = ADDR_SIZE'(NUM_WORDS);
    localparam logic [ADDR_SIZE-1:0] LO_MASK = ADDR_SIZE'(DATA_WIDTH / 8 - 1);
    localparam logic [2:0]           LAT_LOAD = 3'(READ_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [1:0]            resp_q;
    logic [IDX_W-1:0]      index_q;

    logic [ADDR_SIZE-1:0]  offset;
    logic [ADDR_SIZE-1:0]  word_off;
    logic [1:0]            dec_resp;
    logic [IDX_W-1:0]      dec_index;
    logic [DATA_WIDTH-1:0] rd_word;

    // Decode the address presented on the accept edge; the result is latched
    // together with the accept, so the decode sees exactly the captured address.
    always_comb begin
        offset    = araddr - BASE_A;
        word_off  = offset >> BYTE_SHIFT;
        dec_index = word_off[IDX_W-1:0];
        if ((araddr < BASE_A) || (word_off >= WORDS_A)) begin
            dec_resp = RESP_DECERR;
        end else if ((offset & LO_MASK) != '0) begin
            dec_resp = RESP_SLVERR;
        end else begin
            dec_resp = RESP_OKAY;
        end
    end

    // Word mux over the flattened bus; only reached for in-range indices.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (index_q == IDX_W'(i)) begin
                rd_word = data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            resp_q    <= RESP_OKAY;
            index_q   <= '0;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arvalid) begin
                        resp_q  <= dec_resp;
                        index_q <= dec_index;
                        cnt     <= LAT_LOAD;
                        arready <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        // Sample edge: data is captured here and never again.
                        rvalid <= 1'b1;
                        rresp  <= resp_q;
                        rdata  <= (resp_q == RESP_OKAY) ? rd_word : '0;
                        if ((resp_q != RESP_OKAY) && (err_count != '1)) begin
                            err_count <= err_count + ERR_CNT_WIDTH'(1);
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe covers the final WAIT cycle, i.e. the cycle ending at the sample
    // edge, so side-effect registers clear in step with the data being taken.
    assign rd_strobe = (state == ST_WAIT) && (cnt == 3'd0) && (resp_q == RESP_OKAY);
    assign rd_index  = rd_strobe ? index_q : '0;

endmodule

// File: tb/tb_axilite_read_channel.sv
// ---------------------------------------------------------------------------
// tb_axilite_read_channel
//
// Directed bench over three configurations of the read channel sharing one
// clock, reset, data bus, address and rready:
//   u_a  defaults (READ_LATENCY=1, BASE_ADDR=0)
//   u_b  READ_LATENCY=3, ERR_CNT_WIDTH=2
//   u_c  BASE_ADDR=32, READ_LATENCY=4
// Each instance has its own arvalid; the others stay idle while one is used.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_axilite_read_channel;

    logic         clk;
    logic         rst;
    logic [127:0] data;
    logic [31:0]  araddr;
    logic [2:0]   arv;
    logic         rready;

    logic         arready_a, rvalid_a, rd_strobe_a;
    logic [31:0]  rdata_a;
    logic [1:0]   rresp_a, rd_index_a;
    logic [15:0]  err_count_a;

    logic         arready_b, rvalid_b, rd_strobe_b;
    logic [31:0]  rdata_b;
    logic [1:0]   rresp_b, rd_index_b;
    logic [1:0]   err_count_b;

    logic         arready_c, rvalid_c, rd_strobe_c;
    logic [31:0]  rdata_c;
    logic [1:0]   rresp_c, rd_index_c;
    logic [15:0]  err_count_c;

    int total;
    int bad;

    axilite_read_channel u_a (
        .clk(clk), .rst(rst), .data(data), .araddr(araddr), .arvalid(arv[0]),
        .arready(arready_a), .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a),
        .rready(rready), .rd_strobe(rd_strobe_a), .rd_index(rd_index_a),
        .err_count(err_count_a)
    );

    axilite_read_channel #(.READ_LATENCY(3), .ERR_CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .data(data), .araddr(araddr), .arvalid(arv[1]),
        .arready(arready_b), .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b),
        .rready(rready), .rd_strobe(rd_strobe_b), .rd_index(rd_index_b),
        .err_count(err_count_b)
    );

    axilite_read_channel #(.BASE_ADDR(32), .READ_LATENCY(4)) u_c (
        .clk(clk), .rst(rst), .data(data), .araddr(araddr), .arvalid(arv[2]),
        .arready(arready_c), .rdata(rdata_c), .rresp(rresp_c), .rvalid(rvalid_c),
        .rready(rready), .rd_strobe(rd_strobe_c), .rd_index(rd_index_c),
        .err_count(err_count_c)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction on u_a (latency 1), rready given right away.
    task automatic txn_a(input string tag, input logic [31:0] addr,
                         input logic [1:0] resp, input logic [31:0] rd,
                         input logic [1:0] idx);
        araddr = addr;
        arv[0] = 1'b1;
        tick;                                   // E0: accept
        arv[0] = 1'b0;
        check({tag, "_arready_wait"}, arready_a, 0);
        check({tag, "_strobe"}, rd_strobe_a, (resp == 2'd0));
        if (resp == 2'd0) check({tag, "_index"}, rd_index_a, idx);
        check({tag, "_rvalid_early"}, rvalid_a, 0);
        tick;                                   // E1: response loaded
        check({tag, "_rvalid"}, rvalid_a, 1);
        check({tag, "_rdata"}, rdata_a, rd);
        check({tag, "_rresp"}, rresp_a, resp);
        check({tag, "_strobe_off"}, rd_strobe_a, 0);
        rready = 1'b1;
        tick;                                   // E2: R handshake
        rready = 1'b0;
        check({tag, "_rvalid_done"}, rvalid_a, 0);
        check({tag, "_arready_done"}, arready_a, 1);
    endtask

    // One erroneous transaction on u_b (latency 3); checks the saturating counter.
    task automatic txn_b_err(input string tag, input logic [31:0] addr,
                             input logic [1:0] exp_cnt);
        araddr = addr;
        arv[1] = 1'b1;
        tick;                                   // E0
        arv[1] = 1'b0;
        tick;                                   // E1
        tick;                                   // E2: counter at zero
        check({tag, "_no_strobe"}, rd_strobe_b, 0);
        tick;                                   // E3: response loaded
        check({tag, "_rvalid"}, rvalid_b, 1);
        check({tag, "_rresp"}, rresp_b, 2'd2);
        check({tag, "_err_count"}, err_count_b, exp_cnt);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check({tag, "_rvalid_done"}, rvalid_b, 0);
    endtask

    // One full transaction on u_c (latency 4).
    task automatic txn_c(input string tag, input logic [31:0] addr,
                         input logic [1:0] resp, input logic [31:0] rd);
        araddr = addr;
        arv[2] = 1'b1;
        tick;                                   // E0
        arv[2] = 1'b0;
        check({tag, "_arready_wait"}, arready_c, 0);
        check({tag, "_strobe_e0"}, rd_strobe_c, 0);
        for (int i = 0; i < 3; i++) begin       // after E1, E2, E3
            tick;
            check({tag, "_strobe_wait"}, rd_strobe_c, (i == 2) && (resp == 2'd0));
            check({tag, "_rvalid_wait"}, rvalid_c, 0);
        end
        tick;                                   // E4: response loaded
        check({tag, "_rvalid"}, rvalid_c, 1);
        check({tag, "_rdata"}, rdata_c, rd);
        check({tag, "_rresp"}, rresp_c, resp);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check({tag, "_rvalid_done"}, rvalid_c, 0);
        check({tag, "_arready_done"}, arready_c, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        data   = '0;
        araddr = '0;
        arv    = '0;
        rready = 1'b0;

        data[0*32 +: 32] = 32'h0BAD_CAFE;
        data[1*32 +: 32] = 32'h1111_2222;
        data[2*32 +: 32] = 32'hDEAD_BEEF;
        data[3*32 +: 32] = 32'h3333_4444;

        // Reset asserted between edges must act at once.
        #3 rst = 1'b1;
        #1;
        check("rst_arready", arready_a, 1);
        check("rst_rvalid", rvalid_a, 0);
        check("rst_rresp", rresp_a, 0);
        check("rst_err_count", err_count_a, 0);
        check("rst_rdata", rdata_a, 0);
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_rvalid", {rvalid_a, rvalid_b, rvalid_c}, 3'b000);
        end

        // Aligned read, word 2.
        txn_a("aligned", 32'd8, 2'd0, 32'hDEAD_BEEF, 2'd2);

        // Backpressure on u_b: latency 3, rready low for 6 cycles, data
        // changed after the sample edge.
        araddr = 32'd4;
        arv[1] = 1'b1;
        tick;                                   // E0
        arv[1] = 1'b0;
        check("bp_arready", arready_b, 0);
        tick;                                   // E1
        check("bp_strobe_e1", rd_strobe_b, 0);
        tick;                                   // E2
        check("bp_strobe_e2", rd_strobe_b, 1);
        check("bp_index", rd_index_b, 2'd1);
        check("bp_rvalid_e2", rvalid_b, 0);
        tick;                                   // E3
        check("bp_rvalid_e3", rvalid_b, 1);
        check("bp_rdata_e3", rdata_b, 32'h1111_2222);
        check("bp_strobe_e3", rd_strobe_b, 0);
        data[1*32 +: 32] = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("bp_hold_rvalid", rvalid_b, 1);
            check("bp_hold_rdata", rdata_b, 32'h1111_2222);
            check("bp_hold_arready", arready_b, 0);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("bp_rvalid_done", rvalid_b, 0);
        check("bp_arready_done", arready_b, 1);
        check("bp_err_count", err_count_b, 0);

        // Error responses.
        txn_a("slverr", 32'd6, 2'd2, 32'h0, 2'd0);
        txn_a("decerr_top", 32'd16, 2'd3, 32'h0, 2'd0);
        txn_a("decerr_far", 32'hFFFF_FFFC, 2'd3, 32'h0, 2'd0);
        check("a_err_count", err_count_a, 3);
        txn_c("decerr_below", 32'd4, 2'd3, 32'h0);
        check("c_err_count", err_count_c, 1);

        // Saturation with a 2-bit counter.
        for (int k = 1; k <= 5; k++) begin
            txn_b_err("sat", 32'd6, (k > 3) ? 2'd3 : 2'(k));
        end

        // Reset while u_c waits (latency 4), asserted after E1.
        araddr = 32'd40;
        arv[2] = 1'b1;
        tick;                                   // E0
        arv[2] = 1'b0;
        tick;                                   // E1
        #2 rst = 1'b1;
        #1;
        check("rstw_rvalid", rvalid_c, 0);
        check("rstw_strobe", rd_strobe_c, 0);
        check("rstw_arready", arready_c, 1);
        check("rstw_err_c", err_count_c, 0);
        check("rstw_err_a", err_count_a, 0);
        check("rstw_err_b", err_count_b, 0);
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            check("rstw_quiet", {rvalid_c, rd_strobe_c, arready_c}, 3'b001);
        end
        txn_c("after_rst", 32'd32, 2'd0, 32'h0BAD_CAFE);
        check("after_rst_err", err_count_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the flow above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
